// File: rtl/pulse_monitor.sv
// pulse_monitor: measures high time and rising-edge period of an asynchronous pulse train,
// with saturating counters, a low-time timeout and a sticky overflow flag.
module pulse_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] width_out,
  output logic [CNT_W-1:0] period_out,
  output logic [7:0]       pulse_count,
  output logic             overflow,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  state_t st_q, st_d;
  logic [1:0] sync_q;
  logic sd_q;
  logic [CNT_W-1:0] wcnt_q, wcnt_d, pcnt_q, pcnt_d, lcnt_q, lcnt_d, hw_q, hw_d;
  logic [CNT_W-1:0] width_q, width_d, period_q, period_d;
  logic [7:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, mv_q, mv_d, to_q, to_d;
  logic s, rise, fall, w_max, p_max;
  logic [CNT_W-1:0] w_inc, p_inc;
  assign s     = sync_q[1];
  assign rise  = s & ~sd_q;
  assign fall  = ~s & sd_q;
  assign w_max = &wcnt_q;
  assign p_max = &pcnt_q;
  assign w_inc = w_max ? wcnt_q : wcnt_q + ONE;
  assign p_inc = p_max ? pcnt_q : pcnt_q + ONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      sync_q   <= '0;
      sd_q     <= 1'b0;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      lcnt_q   <= '0;
      hw_q     <= '0;
      width_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      mv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      st_q     <= st_d;
      sync_q   <= {sync_q[0], pulse_in};
      sd_q     <= s;
      wcnt_q   <= wcnt_d;
      pcnt_q   <= pcnt_d;
      lcnt_q   <= lcnt_d;
      hw_q     <= hw_d;
      width_q  <= width_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      mv_q     <= mv_d;
      to_q     <= to_d;
    end
  end
  always_comb begin
    st_d     = st_q;
    wcnt_d   = wcnt_q;
    pcnt_d   = pcnt_q;
    lcnt_d   = lcnt_q;
    hw_d     = hw_q;
    width_d  = width_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    mv_d     = 1'b0;
    to_d     = 1'b0;
    case (st_q)
      IDLE: if (rise) begin
        st_d   = HIGH;
        wcnt_d = ONE;
        pcnt_d = ONE;
        cnt_d  = cnt_q + 8'd1;
      end
      HIGH: if (fall) begin
        st_d   = LOW;
        hw_d   = wcnt_q;
        lcnt_d = ONE;
        pcnt_d = p_inc;
        ovf_d  = ovf_q | p_max;
      end else begin
        wcnt_d = w_inc;
        pcnt_d = p_inc;
        ovf_d  = ovf_q | w_max | p_max;
      end
      LOW: if (rise) begin
        // a rise on the timeout cycle still completes the measurement
        st_d     = HIGH;
        mv_d     = 1'b1;
        width_d  = hw_q;
        period_d = pcnt_q;
        cnt_d    = cnt_q + 8'd1;
        wcnt_d   = ONE;
        pcnt_d   = ONE;
      end else if (lcnt_q >= TO) begin
        st_d = IDLE;
        to_d = 1'b1;
        hw_d = '0;
      end else begin
        pcnt_d = p_inc;
        lcnt_d = lcnt_q + ONE;
        ovf_d  = ovf_q | p_max;
      end
      default: st_d = IDLE;
    endcase
  end
  assign meas_valid  = mv_q;
  assign width_out   = width_q;
  assign period_out  = period_q;
  assign pulse_count = cnt_q;
  assign overflow    = ovf_q;
  assign timeout     = to_q;
endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: directed pulse trains with a scoreboard of expected measurements.
module tb_pulse_monitor;
  localparam int TO_A = 20;
  localparam int TO_B = 10;
  typedef struct {int w; int p;} meas_t;
  logic clk = 1'b0;
  logic rst, pulse_in, pulse2;
  logic mv, ov, to, mv2, ov2, to2;
  logic [15:0] w, p;
  logic [3:0] w2, p2;
  logic [7:0] pc, pc2;
  meas_t exp_q[$];
  meas_t exp2_q[$];
  int vectors = 0;
  int miscompares = 0;
  int to_seen = 0;
  int exp_to = 0;
  pulse_monitor #(.CNT_W(16), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .meas_valid(mv), .width_out(w),
    .period_out(p), .pulse_count(pc), .overflow(ov), .timeout(to)
  );
  pulse_monitor #(.CNT_W(4), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst(rst), .pulse_in(pulse2), .meas_valid(mv2), .width_out(w2),
    .period_out(p2), .pulse_count(pc2), .overflow(ov2), .timeout(to2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic monitor();
    meas_t e;
    forever begin
      @(negedge clk);
      if (to) to_seen++;
      if (mv) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_meas: got width=%0d period=%0d, expected no strobe", w, p);
        end else begin
          e = exp_q.pop_front();
          chk("width", w, e.w);
          chk("period", p, e.p);
        end
      end
      if (mv2) begin
        if (exp2_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_meas_b: got width=%0d period=%0d, expected no strobe", w2, p2);
        end else begin
          e = exp2_q.pop_front();
          chk("width_b", w2, e.w);
          chk("period_b", p2, e.p);
        end
      end
    end
  endtask
  task automatic hold(input logic v, input int n);
    pulse_in = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic train(input int h, input int l, input int n);
    for (int i = 1; i < n; i++) exp_q.push_back('{h, h + l});
    for (int i = 0; i < n; i++) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask
  task automatic zeros(input string tag);
    chk({tag, "_mv"}, mv, 0);
    chk({tag, "_width"}, w, 0);
    chk({tag, "_period"}, p, 0);
    chk({tag, "_count"}, pc, 0);
    chk({tag, "_ovf"}, ov, 0);
    chk({tag, "_to"}, to, 0);
  endtask
  task automatic phase_end(input string tag, input int count);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_count"}, pc, count);
    chk({tag, "_timeouts"}, to_seen, exp_to);
    chk({tag, "_ovf"}, ov, 0);
  endtask
  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    pulse2 = 1'b0;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    zeros("reset");
    chk("reset_b_width", w2, 0);
    chk("reset_b_count", pc2, 0);
    rst = 1'b0;
    hold(1'b0, 4);
    // 3 high / 7 low, four pulses, then a long low that times out
    train(3, 7, 4);
    hold(1'b0, 25);
    exp_to++;
    phase_end("periodic", 4);
    // lone pulse times out silently, then a pair measures normally
    hold(1'b1, 3);
    hold(1'b0, TO_A + 5);
    exp_to++;
    chk("lone_timeout", to_seen, exp_to);
    train(4, 6, 2);
    hold(1'b0, 24);
    exp_to++;
    phase_end("timeout", 7);
    train(1, 1, 6);
    hold(1'b0, 30);
    exp_to++;
    phase_end("fastest", 13);
    // rise on the timeout cycle wins; one more low cycle loses it
    train(2, TO_A, 2);
    hold(1'b0, 1);
    exp_to++;
    hold(1'b1, 2);
    hold(1'b0, 30);
    exp_to++;
    phase_end("boundary", 16);
    hold(1'b1, 4);
    #2 rst = 1'b1;
    #1 zeros("async_rst");
    @(negedge clk);
    pulse_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 3);
    zeros("post_rst");
    train(2, 3, 4);
    hold(1'b0, 30);
    exp_to++;
    phase_end("after_rst", 4);
    exp2_q.push_back('{15, 15});
    pulse2 = 1'b1;
    repeat (20) @(negedge clk);
    chk("sat_ovf_high", ov2, 1);
    pulse2 = 1'b0;
    repeat (2) @(negedge clk);
    pulse2 = 1'b1;
    @(negedge clk);
    pulse2 = 1'b0;
    repeat (30) @(negedge clk);
    chk("sat_drain", exp2_q.size(), 0);
    chk("sat_width_held", w2, 15);
    chk("sat_period_held", p2, 15);
    chk("sat_ovf_sticky", ov2, 1);
    chk("sat_count", pc2, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
